// File: rtl/ifu_bus_resp.sv
// ifu_bus_resp: in-order instruction-fetch bus responder backed by a preloadable fixed-latency RAM
module ifu_bus_resp #(
    parameter int ADDR_WIDTH     = 48,
    parameter int DATA_WIDTH     = 128,
    parameter int MEM_DEPTH_BITS = 8,
    parameter int RD_LATENCY     = 2,
    parameter int REQ_FIFO_BITS  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     ifu2bus_ar,
    input  logic                      ifu2bus_ar_valid,
    output logic                      ifu2bus_ar_ready,
    output logic                      ifu2bus_r_valid,
    input  logic                      ifu2bus_r_ready,
    output logic [DATA_WIDTH-1:0]     ifu2bus_data,
    output logic                      ifu2bus_r_err,
    input  logic                      mem_wr_en,
    input  logic [MEM_DEPTH_BITS-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wr_data,
    output logic [REQ_FIFO_BITS:0]    req_level
);
    localparam int DEPTH = 2 ** REQ_FIFO_BITS;
    localparam int CW    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   fifo_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_q [2**MEM_DEPTH_BITS];
    logic [REQ_FIFO_BITS:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    r_valid_q, r_err_q;
    logic [ADDR_WIDTH-1:0]   head, load_addr;
    logic                    push, pop, load, in_range;

    assign req_level        = wr_ptr_q - rd_ptr_q;
    assign ifu2bus_ar_ready = (req_level != DEPTH[REQ_FIFO_BITS:0]);
    assign ifu2bus_r_valid  = r_valid_q;
    assign ifu2bus_data     = data_q;
    assign ifu2bus_r_err    = r_err_q;
    assign push      = ifu2bus_ar_valid & ifu2bus_ar_ready;
    assign pop       = (req_level != '0) & ((state_q == IDLE) | ((state_q == RESP) & ifu2bus_r_ready));
    assign head      = fifo_q[rd_ptr_q[REQ_FIFO_BITS-1:0]];
    // With single-cycle latency the beat is loaded straight from the FIFO head at the pop edge.
    assign load_addr = (RD_LATENCY == 1) ? head : addr_q;
    assign load      = (RD_LATENCY == 1) ? pop : ((state_q == READ) && (cnt_q == CW'(1)));
    assign in_range  = (load_addr[ADDR_WIDTH-1:MEM_DEPTH_BITS] == '0);

    // Preload port; reads sample the pre-write contents at a colliding edge.
    always_ff @(posedge clk) begin
        if (mem_wr_en) mem_q[mem_wr_addr] <= mem_wr_data;
    end

    // Request FIFO storage (not reset; validity is tracked by the pointers).
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[REQ_FIFO_BITS-1:0]] <= ifu2bus_ar;
    end

    // Request FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Service FSM: pop a request, wait out the RAM latency, hold the beat until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            r_err_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            if (load) begin
                data_q  <= in_range ? mem_q[load_addr[MEM_DEPTH_BITS-1:0]] : '0;
                r_err_q <= ~in_range;
            end
            if (pop) begin
                addr_q <= head;
                cnt_q  <= CW'(RD_LATENCY - 1);
            end else if (state_q == READ) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (load) begin
                state_q   <= RESP;
                r_valid_q <= 1'b1;
            end else if (pop) begin
                state_q   <= READ;
                r_valid_q <= 1'b0;
            end else if ((state_q == RESP) && ifu2bus_r_ready) begin
                state_q   <= IDLE;
                r_valid_q <= 1'b0;
            end
        end
    end
endmodule
